// File: rtl/nibble_demux_pkg.sv
// rtl/nibble_demux_pkg.sv - shared encodings and field positions for the nibble demux tile
package nibble_demux_pkg;

  typedef enum logic [1:0] {
    DEST_LO   = 2'b00,
    DEST_HI   = 2'b01,
    DEST_BOTH = 2'b10,
    DEST_PACK = 2'b11
  } dest_e;

  typedef enum logic {
    PACK_LO = 1'b0,
    PACK_HI = 1'b1
  } pack_state_e;

  localparam int UI_NIB_LSB  = 0;
  localparam int UI_NIB_MSB  = 3;
  localparam int UI_STROBE   = 4;
  localparam int UI_DEST_LSB = 5;
  localparam int UI_DEST_MSB = 6;
  localparam int UI_CLEAR    = 7;

  localparam int UIO_FLAG_LO    = 0;
  localparam int UIO_FLAG_HI    = 1;
  localparam int UIO_BYTE_READY = 2;
  localparam int UIO_PACK_STATE = 3;
  localparam int UIO_COUNT_LSB  = 4;
  localparam int UIO_COUNT_MSB  = 7;

endpackage

// File: rtl/strobe_sync.sv
// rtl/strobe_sync.sv - two-flop synchronizer with rising-edge pulse for pin-driven strobes
module strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;

  // Flops reset to 0, so a strobe already high at reset release counts as one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= async_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign rise_pulse = r_sync2 & ~r_hist;

endmodule

// File: rtl/tt_um_nibble_demux.sv
// rtl/tt_um_nibble_demux.sv - nibble demultiplexer and byte packer TinyTapeout tile
module tt_um_nibble_demux
  import nibble_demux_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic        w_wr;
  logic        w_clear;
  logic [3:0]  w_nib;
  dest_e       w_dest;
  logic        w_unused;

  logic [3:0]  r_lo;
  logic [3:0]  r_hi;
  logic        r_flag_lo;
  logic        r_flag_hi;
  logic        r_byte_ready;
  logic [3:0]  r_count;
  pack_state_e r_state;

  strobe_sync u_strobe_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (ui_in[UI_STROBE]),
    .rise_pulse (w_wr)
  );

  assign w_clear  = ui_in[UI_CLEAR];
  assign w_nib    = ui_in[UI_NIB_MSB:UI_NIB_LSB];
  assign w_dest   = dest_e'(ui_in[UI_DEST_MSB:UI_DEST_LSB]);
  assign w_unused = &{1'b0, ena, uio_in};

  // Clear wins over a same-cycle write; the write is dropped, not deferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo         <= 4'h0;
      r_hi         <= 4'h0;
      r_flag_lo    <= 1'b0;
      r_flag_hi    <= 1'b0;
      r_byte_ready <= 1'b0;
      r_count      <= 4'h0;
      r_state      <= PACK_LO;
    end else if (w_clear) begin
      r_lo         <= 4'h0;
      r_hi         <= 4'h0;
      r_flag_lo    <= 1'b0;
      r_flag_hi    <= 1'b0;
      r_byte_ready <= 1'b0;
      r_count      <= 4'h0;
      r_state      <= PACK_LO;
    end else begin
      r_byte_ready <= 1'b0;
      if (w_wr) begin
        r_count <= r_count + 4'd1;
        case (w_dest)
          DEST_LO: begin
            r_lo      <= w_nib;
            r_flag_lo <= 1'b1;
            r_state   <= PACK_LO;
          end
          DEST_HI: begin
            r_hi      <= w_nib;
            r_flag_hi <= 1'b1;
            r_state   <= PACK_LO;
          end
          DEST_BOTH: begin
            r_lo      <= w_nib;
            r_hi      <= w_nib;
            r_flag_lo <= 1'b1;
            r_flag_hi <= 1'b1;
            r_state   <= PACK_LO;
          end
          DEST_PACK: begin
            if (r_state == PACK_LO) begin
              // Starting a new byte: stale flags go, low flag re-set by this write.
              r_lo      <= w_nib;
              r_flag_lo <= 1'b1;
              r_flag_hi <= 1'b0;
              r_state   <= PACK_HI;
            end else begin
              r_hi         <= w_nib;
              r_flag_hi    <= 1'b1;
              r_byte_ready <= 1'b1;
              r_state      <= PACK_LO;
            end
          end
          default: begin
            r_state <= PACK_LO;
          end
        endcase
      end
    end
  end

  assign uo_out  = {r_hi, r_lo};
  assign uio_out = {r_count, r_state, r_byte_ready, r_flag_hi, r_flag_lo};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_nibble_demux.sv
// tb/tb_tt_um_nibble_demux.sv - scoreboard bench for the nibble demux tile
module tb_tt_um_nibble_demux;
  import nibble_demux_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct {
    logic [7:0] uo;
    logic [7:0] uio;
    int         id;
  } exp_t;

  exp_t       q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  bit         mon_en = 0;
  logic [3:0] last_cnt;

  tt_um_nibble_demux dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [7:0] euo, input logic [7:0] euio, input int id);
    exp_t e;
    e.uo  = euo;
    e.uio = euio;
    e.id  = id;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  // One strobe: high 3 cycles, low 3; data held until after the update edge.
  task automatic wr(input logic [3:0] nib, input logic [1:0] dest,
                    input logic [7:0] euo, input logic [7:0] euio,
                    input int id, input bit clr_hit);
    @(negedge clk);
    ui_in[3:0] = nib;
    ui_in[6:5] = dest;
    ui_in[4]   = 1'b1;
    push(euo, euio, id);
    repeat (2) @(negedge clk);
    if (clr_hit) ui_in[7] = 1'b1;
    @(negedge clk);
    ui_in[7] = 1'b0;
    ui_in[4] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clr(input int id);
    @(negedge clk);
    ui_in[7] = 1'b1;
    push(8'h00, 8'h00, id);
    @(negedge clk);
    ui_in[7] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Every accepted write (and clear/reset) moves the count field.
  initial begin
    exp_t e;
    wait (mon_en);
    last_cnt = 4'h0;
    forever begin
      @(negedge clk);
      if (uio_out[7:4] !== last_cnt) begin
        last_cnt = uio_out[7:4];
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_update: got uo=%h uio=%h, want no update", uo_out, uio_out);
        end else begin
          e = q.pop_front();
          if (uo_out !== e.uo || uio_out !== e.uio) begin
            n_bad++;
            $display("FAIL vec%0d: got uo=%h uio=%h, want uo=%h uio=%h",
                     e.id, uo_out, uio_out, e.uo, e.uio);
          end
        end
        @(negedge clk);
        n_vec++;
        if (uio_out[2] !== 1'b0) begin
          n_bad++;
          $display("FAIL byte_ready_width: got %b one cycle later, want 0", uio_out[2]);
        end
      end
    end
  end

  initial begin
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h00;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_uo", uo_out, 8'h00);
    chk("reset_uio", uio_out, 8'h00);
    chk("uio_oe", uio_oe, 8'hFF);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    wr(4'hA, DEST_LO,   8'h0A, 8'h11, 1, 0);
    clr(2);
    wr(4'h5, DEST_BOTH, 8'h55, 8'h13, 3, 0);
    wr(4'hC, DEST_HI,   8'hC5, 8'h23, 4, 0);
    wr(4'h3, DEST_PACK, 8'hC3, 8'h39, 5, 0);
    wr(4'h9, DEST_PACK, 8'h93, 8'h47, 6, 0);
    wr(4'h7, DEST_PACK, 8'h97, 8'h59, 7, 0);
    wr(4'h1, DEST_LO,   8'h91, 8'h61, 8, 0);
    wr(4'h2, DEST_PACK, 8'h92, 8'h79, 9, 0);
    clr(10);

    for (int k = 1; k <= 17; k++) begin
      logic [3:0] kn;
      kn = k[3:0];
      wr(kn, DEST_LO, {4'h0, kn}, {kn, 4'h1}, 100 + k, 0);
    end

    wr(4'hF, DEST_LO, 8'h00, 8'h00, 200, 1);
    repeat (4) @(negedge clk);
    chk("clear_drop_uo", uo_out, 8'h00);
    chk("clear_drop_uio", uio_out, 8'h00);

    wr(4'hD, DEST_HI,   8'hD0, 8'h12, 300, 0);
    wr(4'h6, DEST_PACK, 8'hD6, 8'h29, 301, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    push(8'h00, 8'h00, 302);
    #1;
    chk("async_reset_uo", uo_out, 8'h00);
    chk("async_reset_uio", uio_out, 8'h00);
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wr(4'h4, DEST_LO, 8'h04, 8'h11, 303, 0);

    repeat (5) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
